// File: rtl/muldiv_unit_if.sv
// Start/done handshake and HI/LO result bus between the control unit and the
// iterative multiply/divide unit.
interface muldiv_unit_if #(
  parameter int n = 32
);
  logic         start;
  logic [1:0]   op;
  logic [n-1:0] a;
  logic [n-1:0] b;
  logic         busy;
  logic         done;
  logic [n-1:0] hi;
  logic [n-1:0] lo;
  logic         div_by_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle mult/multu/div/divu unit: shift-add multiply and restoring divide
// on operand magnitudes, one bit per cycle, with a final sign-fix cycle.
module muldiv_unit #(
  parameter int n = 32
) (
  input logic          clk,
  input logic          reset,
  muldiv_unit_if.slave bus
);
  localparam int cw = $clog2(n + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t         state_r;
  state_t         state_s;
  logic [cw-1:0]  cnt_r;
  logic           is_div_r;
  logic           zero_r;
  logic           neg_res_r;
  logic           neg_rem_r;
  logic [n-1:0]   mcand_r;
  logic [2*n-1:0] prod_r;
  logic [n-1:0]   rem_r;
  logic [n-1:0]   quo_r;
  logic [n-1:0]   hi_r;
  logic [n-1:0]   lo_r;
  logic           dbz_r;
  logic           busy_r;
  logic           done_r;

  logic           is_signed_s;
  logic           is_div_s;
  logic           neg_a_s;
  logic           neg_b_s;
  logic [n-1:0]   mag_a_s;
  logic [n-1:0]   mag_b_s;
  logic           b_zero_s;
  logic [n:0]     mul_sum_s;
  logic [2*n-1:0] mul_next_s;
  logic [n:0]     shift_s;
  logic           ge_s;
  logic [n-1:0]   rem_next_s;
  logic [n-1:0]   quo_next_s;
  logic [2*n-1:0] prod_fix_s;
  logic [n-1:0]   quo_fix_s;
  logic [n-1:0]   rem_fix_s;

  // Operand decode; |MIN| = 2^(n-1) falls out of n-bit negation as unsigned.
  always_comb begin
    is_signed_s = bus.op[0];
    is_div_s    = bus.op[1];
    neg_a_s     = is_signed_s & bus.a[n-1];
    neg_b_s     = is_signed_s & bus.b[n-1];
    b_zero_s    = (bus.b == {n{1'b0}});
    if (neg_a_s) begin
      mag_a_s = -bus.a;
    end else begin
      mag_a_s = bus.a;
    end
    if (neg_b_s) begin
      mag_b_s = -bus.b;
    end else begin
      mag_b_s = bus.b;
    end
  end

  // One multiply and one divide iteration, plus the sign-corrected results.
  always_comb begin
    if (prod_r[0]) begin
      mul_sum_s = {1'b0, prod_r[2*n-1:n]} + {1'b0, mcand_r};
    end else begin
      mul_sum_s = {1'b0, prod_r[2*n-1:n]};
    end
    mul_next_s = {mul_sum_s, prod_r[n-1:1]};

    // The partial remainder stays below the divisor, so an n-bit difference is exact.
    shift_s = {rem_r, quo_r[n-1]};
    ge_s    = (shift_s >= {1'b0, mcand_r});
    if (ge_s) begin
      rem_next_s = shift_s[n-1:0] - mcand_r;
      quo_next_s = {quo_r[n-2:0], 1'b1};
    end else begin
      rem_next_s = shift_s[n-1:0];
      quo_next_s = {quo_r[n-2:0], 1'b0};
    end

    if (neg_res_r) begin
      prod_fix_s = -prod_r;
      quo_fix_s  = -quo_r;
    end else begin
      prod_fix_s = prod_r;
      quo_fix_s  = quo_r;
    end
    if (neg_rem_r) begin
      rem_fix_s = -rem_r;
    end else begin
      rem_fix_s = rem_r;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; divide by zero skips CALC but still spends the FIX cycle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          if (is_div_s && b_zero_s) begin
            state_s = FIX;
          end else begin
            state_s = CALC;
          end
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == cw'(n - 1)) begin
          state_s = FIX;
        end else begin
          state_s = CALC;
        end
      end
      FIX:     state_s = DONE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Operand latch and iteration datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r     <= {cw{1'b0}};
      is_div_r  <= 1'b0;
      zero_r    <= 1'b0;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      mcand_r   <= {n{1'b0}};
      prod_r    <= {(2*n){1'b0}};
      rem_r     <= {n{1'b0}};
      quo_r     <= {n{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            cnt_r     <= {cw{1'b0}};
            is_div_r  <= is_div_s;
            zero_r    <= is_div_s & b_zero_s;
            neg_res_r <= neg_a_s ^ neg_b_s;
            neg_rem_r <= neg_a_s;
            mcand_r   <= is_div_s ? mag_b_s : mag_a_s;
            prod_r    <= {{n{1'b0}}, mag_b_s};
            rem_r     <= {n{1'b0}};
            // A zero divisor reports the raw dividend in hi, so keep A unmodified.
            quo_r     <= (is_div_s && b_zero_s) ? bus.a : mag_a_s;
          end
        end
        CALC: begin
          cnt_r <= cnt_r + cw'(1);
          if (is_div_r) begin
            rem_r <= rem_next_s;
            quo_r <= quo_next_s;
          end else begin
            prod_r <= mul_next_s;
          end
        end
        FIX:     cnt_r <= {cw{1'b0}};
        DONE:    cnt_r <= {cw{1'b0}};
        default: cnt_r <= {cw{1'b0}};
      endcase
    end
  end

  // HI/LO and divide-by-zero flag, written only on the way into DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_r  <= {n{1'b0}};
      lo_r  <= {n{1'b0}};
      dbz_r <= 1'b0;
    end else if (state_r == FIX) begin
      if (zero_r) begin
        hi_r  <= quo_r;
        lo_r  <= {n{1'b1}};
        dbz_r <= 1'b1;
      end else if (is_div_r) begin
        hi_r  <= rem_fix_s;
        lo_r  <= quo_fix_s;
        dbz_r <= 1'b0;
      end else begin
        hi_r  <= prod_fix_s[2*n-1:n];
        lo_r  <= prod_fix_s[n-1:0];
        dbz_r <= 1'b0;
      end
    end
  end

  // busy and done registered from the next state so they track state_r exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_s != IDLE);
      done_r <= (state_s == DONE);
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.hi          = hi_r;
  assign bus.lo          = lo_r;
  assign bus.div_by_zero = dbz_r;
endmodule
